noc_output_scheduler: RTL and testbench
=======================================

Name: noc_output_scheduler

Overview:
- Per-output-port scheduler for the NOC crossbar. One instance per output column.
- Arbitrates RADIX_IN input FIFOs for one downstream FIFO using round-robin priority.
- Holds the grant for the full length of multi-flit packets (wormhole lock).
- Replaces the downstream full signal with a local credit counter.
- Drives the input-FIFO dequeue vector, the crossbar mux select and the downstream enqueue.

Parameters:
- RADIX_IN, 4: number of requesting input FIFOs.
- CREDITS, 2: downstream FIFO depth, which is the initial credit count.
- LEN_WIDTH, 4: width of the per-input packet-length field.

Ports:
- clk  input  1  clock.
- rst_l  input  1  reset. Asynchronous, active-low.
- request  input  RADIX_IN  bit i set: input FIFO i is non-empty and its head flit targets this output.
- req_len  input  RADIX_IN*LEN_WIDTH  per-input flits remaining after the head flit. 0 means a single-flit packet. Sampled only at head grant.
- deq  output  RADIX_IN  one-hot dequeue to the input FIFOs. Combinational.
- mux_sel  output  $clog2(RADIX_IN)  crossbar select, equal to the index of the deq bit. Combinational.
- FIFO_ENQ  output  1  downstream enqueue, equal to |deq.
- credit_return  input  1  downstream FIFO dequeued one entry.
- credit_count  output  $clog2(CREDITS)+1  current credits. Registered.
- busy  output  1  high in LOCKED. Registered.
- credit_err  output  1  sticky: credit_return arrived with credit_count==CREDITS.

Behaviour:
- Reset (async, rst_l low):
  - state=IDLE, credit_count=CREDITS, rr priority starts at index 0, remaining=0, owner=0, busy=0, credit_err=0.
  - deq, mux_sel and FIFO_ENQ are forced to 0 while rst_l is low.
  - Reset mid-packet abandons the lock. No flit is issued during reset.
- Issue condition: a flit is issued in a cycle iff FIFO_ENQ=1. Grant, dequeue and enqueue happen in the same cycle as the request (0-cycle combinational latency). State updates on the next posedge.
- Credits:
  - No issue when credit_count==0.
  - Update on each posedge:
    - issue and no return: decrement.
    - return and no issue: increment.
    - both: unchanged.
    - return with count==CREDITS and no issue: count stays CREDITS, credit_err is set.
- IDLE state:
  - If credit_count>0 and request!=0, grant g = the first requesting index at or after the rr pointer, wrapping modulo RADIX_IN.
  - Drive deq[g]=1, mux_sel=g, FIFO_ENQ=1.
  - rr pointer <= (g+1) mod RADIX_IN.
  - If req_len[g]==0: stay in IDLE.
  - Else: go to LOCKED, owner<=g, remaining<=req_len[g].
- LOCKED state:
  - Only the owner is eligible. All other requests are ignored.
  - Issue iff request[owner] && credit_count>0. Then deq[owner]=1, mux_sel=owner, remaining<=remaining-1.
  - An issue with remaining==1 returns to IDLE at the next edge.
  - request[owner]=0 produces a bubble. Stay LOCKED with remaining unchanged.
  - The rr pointer does not move while LOCKED.
- Back-to-back: a packet can start in the cycle after the previous tail. With no bubbles, throughput is one flit per cycle when credits allow.
- Width rules:
  - remaining is LEN_WIDTH bits. The maximum packet is 2^LEN_WIDTH flits.
  - credit_count never exceeds CREDITS and never underflows.
- mux_sel=0 when deq=0.

Test Plan:
- Reset, request=4'b1011, all req_len=0, credit_return tied to FIFO_ENQ: grants 0,1,3,0,1,3 on consecutive cycles. mux_sel matches and deq is one-hot each cycle.
- CREDITS=2, request=4'b0001, req_len=0, no credit_return: FIFO_ENQ=1 for 2 cycles, then 0. credit_count goes 2,1,0. One credit_return pulse gives exactly one more issue.
- request=4'b0011, req_len[0]=3: deq=0001 for 4 consecutive flits (busy=1 on flits 2–4). Input 1 is then granted on the 5th cycle.
- Locked on input 2 with remaining=2, request[2] dropped for 3 cycles: no deq during the gap and busy stays 1. On resume, 2 flits issue and then the scheduler returns to IDLE.
- rst_l pulsed low mid-packet (remaining=2, credit_count=0): outputs go to 0 immediately. After release: busy=0, credit_count=2, and a request from input 3 is granted as a fresh head.
- credit_return pulsed with credit_count=2 and no issue: credit_count stays 2, credit_err=1 and it remains 1 until reset.

Source files
------------

// File: rtl/noc_output_scheduler.sv
// Per-output-port scheduler: round-robin arbitration over the input FIFOs,
// wormhole lock for multi-flit packets, and credit-based downstream flow control.
module noc_output_scheduler #(
    parameter int RADIX_IN  = 4,
    parameter int CREDITS   = 2,
    parameter int LEN_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_l,
    input  logic [RADIX_IN-1:0]             request,
    input  logic [RADIX_IN*LEN_WIDTH-1:0]   req_len,
    output logic [RADIX_IN-1:0]             deq,
    output logic [$clog2(RADIX_IN)-1:0]     mux_sel,
    output logic                            FIFO_ENQ,
    input  logic                            credit_return,
    output logic [$clog2(CREDITS):0]        credit_count,
    output logic                            busy,
    output logic                            credit_err
);

    localparam int IDX_W = $clog2(RADIX_IN);
    localparam int CNT_W = $clog2(CREDITS) + 1;
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDITS);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     rrPtr_q;
    logic [IDX_W-1:0]     rrPtr_d;
    logic [IDX_W-1:0]     owner_q;
    logic [LEN_WIDTH-1:0] remaining_q;
    logic [CNT_W-1:0]     credit_q;
    logic [CNT_W-1:0]     credit_d;
    logic                 busy_q;
    logic                 creditErr_q;
    logic                 creditErr_d;

    logic [IDX_W-1:0]     grantIdx;
    logic                 grantFound;
    logic [IDX_W-1:0]     selIdx;
    logic                 issue;
    logic [LEN_WIDTH-1:0] headLen;
    int                   candIdx;

    // Rotating priority search: first requester at or after the rr pointer.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        candIdx    = 0;
        for (int k = 0; k < RADIX_IN; k++) begin
            candIdx = (int'(rrPtr_q) + k) % RADIX_IN;
            if (!grantFound && request[candIdx]) begin
                grantFound = 1'b1;
                grantIdx   = IDX_W'(candIdx);
            end
        end
        rrPtr_d = IDX_W'((int'(grantIdx) + 1) % RADIX_IN);
        headLen = req_len[int'(grantIdx)*LEN_WIDTH +: LEN_WIDTH];
    end

    // Reset gates the issue path so nothing leaks out while rst_l is low.
    always_comb begin
        issue   = 1'b0;
        selIdx  = '0;
        deq     = '0;
        mux_sel = '0;
        if (rst_l && (credit_q != '0)) begin
            if (state_q == IDLE) begin
                issue  = grantFound;
                selIdx = grantIdx;
            end else begin
                issue  = request[owner_q];
                selIdx = owner_q;
            end
        end
        if (issue) begin
            deq[selIdx] = 1'b1;
            mux_sel     = selIdx;
        end
    end

    always_comb begin
        credit_d    = credit_q;
        creditErr_d = creditErr_q;
        if (issue && !credit_return) begin
            credit_d = credit_q - CNT_W'(1);
        end else if (!issue && credit_return) begin
            if (credit_q == CREDIT_MAX) begin
                creditErr_d = 1'b1;
            end else begin
                credit_d = credit_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= IDLE;
            rrPtr_q     <= '0;
            owner_q     <= '0;
            remaining_q <= '0;
            credit_q    <= CREDIT_MAX;
            busy_q      <= 1'b0;
            creditErr_q <= 1'b0;
        end else begin
            credit_q    <= credit_d;
            creditErr_q <= creditErr_d;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        rrPtr_q <= rrPtr_d;
                        if (headLen != '0) begin
                            state_q     <= LOCKED;
                            busy_q      <= 1'b1;
                            owner_q     <= grantIdx;
                            remaining_q <= headLen;
                        end
                    end
                end
                LOCKED: begin
                    // The rr pointer is frozen here; only the owner advances.
                    if (issue) begin
                        remaining_q <= remaining_q - LEN_WIDTH'(1);
                        if (remaining_q == LEN_WIDTH'(1)) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign FIFO_ENQ     = issue;
    assign credit_count = credit_q;
    assign busy         = busy_q;
    assign credit_err   = creditErr_q;

endmodule

// File: tb/tb_noc_output_scheduler.sv
// Scenario bench for noc_output_scheduler: expected dequeue vectors are queued
// as stimulus is driven and popped when the combinational outputs are sampled.
module tb_noc_output_scheduler;

    localparam int RADIX_IN  = 4;
    localparam int CREDITS   = 2;
    localparam int LEN_WIDTH = 4;

    logic        clk;
    logic        rst_l;
    logic [3:0]  request;
    logic [15:0] req_len;
    logic [3:0]  deq;
    logic [1:0]  mux_sel;
    logic        FIFO_ENQ;
    logic        credit_return;
    logic [1:0]  credit_count;
    logic        busy;
    logic        credit_err;

    logic        returnDrv;
    logic        tieReturn;
    logic [3:0]  expQ[$];
    logic [3:0]  expDeq;
    int          compared   = 0;
    int          mismatched = 0;

    assign credit_return = tieReturn ? FIFO_ENQ : returnDrv;

    noc_output_scheduler #(
        .RADIX_IN (RADIX_IN),
        .CREDITS  (CREDITS),
        .LEN_WIDTH(LEN_WIDTH)
    ) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .request      (request),
        .req_len      (req_len),
        .deq          (deq),
        .mux_sel      (mux_sel),
        .FIFO_ENQ     (FIFO_ENQ),
        .credit_return(credit_return),
        .credit_count (credit_count),
        .busy         (busy),
        .credit_err   (credit_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [1:0] idxOf(input logic [3:0] oneHot);
        idxOf = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oneHot[i]) idxOf = 2'(i);
        end
    endfunction

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        rst_l     = 1'b0;
        request   = 4'b0000;
        req_len   = 16'h0000;
        returnDrv = 1'b0;
        tieReturn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_l = 1'b1;
    endtask

    task automatic test_reset;
        rst_l     = 1'b0;
        request   = 4'b1111;
        req_len   = 16'h0000;
        returnDrv = 1'b0;
        tieReturn = 1'b0;
        @(negedge clk);
        compared++;
        if (deq !== 4'b0000 || FIFO_ENQ !== 1'b0 || mux_sel !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: deq=%b enq=%b sel=%0d, expected all zero", deq, FIFO_ENQ, mux_sel);
        end
        compared++;
        if (credit_count !== 2'd2 || busy !== 1'b0 || credit_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: credits=%0d busy=%b err=%b, expected 2/0/0", credit_count, busy, credit_err);
        end
        @(posedge clk);
        #1;
        rst_l   = 1'b1;
        request = 4'b0000;
        @(negedge clk);
        compared++;
        if (FIFO_ENQ !== 1'b0 || credit_count !== 2'd2) begin
            mismatched++;
            $display("[TB] FAIL reset_release_idle: enq=%b credits=%0d, expected 0/2", FIFO_ENQ, credit_count);
        end
        nextCycle();
    endtask

    task automatic test_round_robin;
        logic [3:0] seq [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        doReset();
        tieReturn = 1'b1;
        request   = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            expQ.push_back(seq[i]);
            @(negedge clk);
            expDeq = expQ.pop_front();
            compared++;
            if (deq !== expDeq || FIFO_ENQ !== (|expDeq) || mux_sel !== idxOf(expDeq)) begin
                mismatched++;
                $display("[TB] FAIL rr_grant[%0d]: deq=%b enq=%b sel=%0d, expected deq=%b", i, deq, FIFO_ENQ, mux_sel, expDeq);
            end
            compared++;
            if (credit_count !== 2'd2 || busy !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL rr_credits[%0d]: credits=%0d busy=%b, expected 2/0", i, credit_count, busy);
            end
            nextCycle();
        end
        request = 4'b0000;
        @(negedge clk);
        compared++;
        if (credit_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rr_no_err: credit_err=%b, expected 0", credit_err);
        end
        tieReturn = 1'b0;
        nextCycle();
    endtask

    task automatic test_credits;
        logic [3:0] seqDeq [6] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        logic [1:0] seqCnt [6] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0};
        logic       seqRet [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        doReset();
        request = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            returnDrv = seqRet[i];
            expQ.push_back(seqDeq[i]);
            @(negedge clk);
            expDeq = expQ.pop_front();
            compared++;
            if (deq !== expDeq || FIFO_ENQ !== (|expDeq) || mux_sel !== idxOf(expDeq)) begin
                mismatched++;
                $display("[TB] FAIL credit_issue[%0d]: deq=%b enq=%b sel=%0d, expected deq=%b", i, deq, FIFO_ENQ, mux_sel, expDeq);
            end
            compared++;
            if (credit_count !== seqCnt[i]) begin
                mismatched++;
                $display("[TB] FAIL credit_count[%0d]: got %0d, expected %0d", i, credit_count, seqCnt[i]);
            end
            nextCycle();
        end
        request   = 4'b0000;
        returnDrv = 1'b0;
    endtask

    task automatic test_wormhole;
        logic [3:0] seqDeq  [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        logic       seqBusy [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        doReset();
        tieReturn    = 1'b1;
        request      = 4'b0011;
        req_len[3:0] = 4'd3;
        req_len[7:4] = 4'd0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) req_len[3:0] = 4'd0;
            expQ.push_back(seqDeq[i]);
            @(negedge clk);
            expDeq = expQ.pop_front();
            compared++;
            if (deq !== expDeq || FIFO_ENQ !== (|expDeq) || mux_sel !== idxOf(expDeq)) begin
                mismatched++;
                $display("[TB] FAIL wormhole_flit[%0d]: deq=%b enq=%b sel=%0d, expected deq=%b", i, deq, FIFO_ENQ, mux_sel, expDeq);
            end
            compared++;
            if (busy !== seqBusy[i]) begin
                mismatched++;
                $display("[TB] FAIL wormhole_busy[%0d]: got %b, expected %b", i, busy, seqBusy[i]);
            end
            nextCycle();
        end
        request   = 4'b0000;
        tieReturn = 1'b0;
    endtask

    task automatic test_bubble;
        logic [3:0] seqReq  [7] = '{4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0000};
        logic [3:0] seqDeq  [7] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
        logic       seqBusy [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        doReset();
        tieReturn      = 1'b1;
        req_len[11:8]  = 4'd2;
        for (int i = 0; i < 7; i++) begin
            request = seqReq[i];
            expQ.push_back(seqDeq[i]);
            @(negedge clk);
            expDeq = expQ.pop_front();
            compared++;
            if (deq !== expDeq || FIFO_ENQ !== (|expDeq) || mux_sel !== idxOf(expDeq)) begin
                mismatched++;
                $display("[TB] FAIL bubble_flit[%0d]: deq=%b enq=%b sel=%0d, expected deq=%b", i, deq, FIFO_ENQ, mux_sel, expDeq);
            end
            compared++;
            if (busy !== seqBusy[i]) begin
                mismatched++;
                $display("[TB] FAIL bubble_busy[%0d]: got %b, expected %b", i, busy, seqBusy[i]);
            end
            nextCycle();
        end
        tieReturn = 1'b0;
    endtask

    task automatic test_max_packet;
        doReset();
        tieReturn    = 1'b1;
        request      = 4'b0010;
        req_len[7:4] = 4'd15;
        for (int i = 0; i < 17; i++) begin
            expQ.push_back(4'b0010);
            @(negedge clk);
            expDeq = expQ.pop_front();
            compared++;
            if (deq !== expDeq || FIFO_ENQ !== 1'b1 || mux_sel !== 2'd1) begin
                mismatched++;
                $display("[TB] FAIL max_packet_flit[%0d]: deq=%b enq=%b sel=%0d, expected deq=%b", i, deq, FIFO_ENQ, mux_sel, expDeq);
            end
            compared++;
            if (busy !== ((i >= 1 && i <= 15) ? 1'b1 : 1'b0)) begin
                mismatched++;
                $display("[TB] FAIL max_packet_busy[%0d]: got %b, expected %b", i, busy, (i >= 1 && i <= 15));
            end
            nextCycle();
        end
        request   = 4'b0000;
        tieReturn = 1'b0;
    endtask

    task automatic test_reset_mid_packet;
        logic [3:0] seqDeq  [3] = '{4'b0001, 4'b0001, 4'b0000};
        logic [1:0] seqCnt  [3] = '{2'd2, 2'd1, 2'd0};
        logic       seqBusy [3] = '{1'b0, 1'b1, 1'b1};
        doReset();
        request      = 4'b0001;
        req_len[3:0] = 4'd3;
        for (int i = 0; i < 3; i++) begin
            expQ.push_back(seqDeq[i]);
            @(negedge clk);
            expDeq = expQ.pop_front();
            compared++;
            if (deq !== expDeq || FIFO_ENQ !== (|expDeq) || credit_count !== seqCnt[i] || busy !== seqBusy[i]) begin
                mismatched++;
                $display("[TB] FAIL midpkt_pre[%0d]: deq=%b enq=%b credits=%0d busy=%b, expected deq=%b credits=%0d busy=%b",
                         i, deq, FIFO_ENQ, credit_count, busy, expDeq, seqCnt[i], seqBusy[i]);
            end
        end
        rst_l = 1'b0;
        #1;
        compared++;
        if (deq !== 4'b0000 || FIFO_ENQ !== 1'b0 || mux_sel !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL midpkt_reset_outputs: deq=%b enq=%b sel=%0d, expected all zero", deq, FIFO_ENQ, mux_sel);
        end
        compared++;
        if (busy !== 1'b0 || credit_count !== 2'd2) begin
            mismatched++;
            $display("[TB] FAIL midpkt_reset_state: busy=%b credits=%0d, expected 0/2", busy, credit_count);
        end
        nextCycle();
        rst_l        = 1'b1;
        request      = 4'b1000;
        req_len      = 16'h0000;
        expQ.push_back(4'b1000);
        @(negedge clk);
        expDeq = expQ.pop_front();
        compared++;
        if (deq !== expDeq || FIFO_ENQ !== 1'b1 || mux_sel !== 2'd3 || busy !== 1'b0 || credit_count !== 2'd2) begin
            mismatched++;
            $display("[TB] FAIL midpkt_fresh_head: deq=%b sel=%0d busy=%b credits=%0d, expected deq=%b sel=3 busy=0 credits=2",
                     deq, mux_sel, busy, credit_count, expDeq);
        end
        nextCycle();
        request = 4'b0000;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || credit_count !== 2'd1) begin
            mismatched++;
            $display("[TB] FAIL midpkt_after_head: busy=%b credits=%0d, expected 0/1", busy, credit_count);
        end
        nextCycle();
    endtask

    task automatic test_credit_err;
        doReset();
        returnDrv = 1'b1;
        @(negedge clk);
        compared++;
        if (credit_count !== 2'd2 || credit_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL err_before: credits=%0d err=%b, expected 2/0", credit_count, credit_err);
        end
        nextCycle();
        returnDrv = 1'b0;
        @(negedge clk);
        compared++;
        if (credit_count !== 2'd2 || credit_err !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL err_set: credits=%0d err=%b, expected 2/1", credit_count, credit_err);
        end
        nextCycle();
        request = 4'b0001;
        expQ.push_back(4'b0001);
        @(negedge clk);
        expDeq = expQ.pop_front();
        compared++;
        if (deq !== expDeq || credit_err !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL err_sticky_issue: deq=%b err=%b, expected deq=%b err=1", deq, credit_err, expDeq);
        end
        nextCycle();
        request = 4'b0000;
        @(negedge clk);
        compared++;
        if (credit_err !== 1'b1 || credit_count !== 2'd1) begin
            mismatched++;
            $display("[TB] FAIL err_sticky_hold: err=%b credits=%0d, expected 1/1", credit_err, credit_count);
        end
        doReset();
        @(negedge clk);
        compared++;
        if (credit_err !== 1'b0 || credit_count !== 2'd2) begin
            mismatched++;
            $display("[TB] FAIL err_cleared: err=%b credits=%0d, expected 0/2", credit_err, credit_count);
        end
        nextCycle();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_credits();
        test_wormhole();
        test_bubble();
        test_max_packet();
        test_reset_mid_packet();
        test_credit_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
